// File: rtl/rtype_sequencer.sv
// rtype_sequencer
//   Multi-cycle control FSM for an R-type ALU datapath. Every instruction
//   walks FETCH -> DECODE -> EXEC -> WB, one cycle each. The block pulses
//   the PC and IR load strobes, drives ALUOp, pulses RegWrite, counts
//   retired instructions and traps on unsupported function codes.
//
//   Ports
//     CLK        system clock, all state changes on posedge
//     RESET      synchronous active-high reset, dominates every other input
//     run        level: 1 = keep executing, 0 = stop at next instruction boundary
//     funct      INSTRUCTION[5:0] from the instruction register
//     alu_zero   ALU Zero flag, folded into zero_seen during WB
//     pc_write   load PC from the PC adder (FETCH pulse)
//     ir_write   latch INSTRUCTION into the IR (FETCH pulse)
//     alu_op     2'b00 idle/add, 2'b10 R-type (DECODE, EXEC, WB)
//     reg_write  register-file write enable (WB pulse)
//     state      0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 WB, 5 TRAP
//     busy       high in FETCH/DECODE/EXEC/WB
//     done       one-cycle pulse in the first IDLE cycle after WB
//     illegal    sticky, set on entry to TRAP
//     zero_seen  sticky OR of alu_zero over WB cycles, cleared on IDLE->FETCH
//     instr_cnt  saturating retired-instruction count
//
//   Handshake: there is no valid/ready pair. run is a level that is only
//   sampled in IDLE and WB; once FETCH is entered the instruction always
//   completes (or traps) regardless of run.
//
//   All outputs are registered and decoded from the next state, so each
//   strobe is aligned with the state value visible on the state port.

module rtype_sequencer #(
  parameter int COUNT_W   = 16,
  parameter int MAX_INSTR = 0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               run,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [2:0]         state,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               zero_seen,
  output logic [COUNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  state_t      r_state;
  logic [31:0] r_run_cnt;   // retirements since the last IDLE->FETCH

  state_t      w_next;
  logic        w_legal;
  logic        w_limit;
  logic [31:0] w_run_cnt_inc;

  // ADD, SUB, AND, OR, NOR, SLT
  always_comb begin
    w_legal = 1'b0;
    case (funct)
      6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: w_legal = 1'b1;
      default:                                  w_legal = 1'b0;
    endcase
  end

  // Count including the instruction retiring in this WB cycle.
  assign w_run_cnt_inc = (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + 32'd1;
  assign w_limit       = (MAX_INSTR != 0) && (w_run_cnt_inc >= 32'(MAX_INSTR));

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = (run && !w_limit) ? S_FETCH : S_IDLE;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;  // encodes 6 and 7 recover to IDLE
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
      pc_write  <= 1'b0;
      ir_write  <= 1'b0;
      alu_op    <= ALU_OP_ADD;
      reg_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      zero_seen <= 1'b0;
      instr_cnt <= '0;
    end else begin
      r_state   <= w_next;

      pc_write  <= (w_next == S_FETCH);
      ir_write  <= (w_next == S_FETCH);
      alu_op    <= (w_next == S_DECODE || w_next == S_EXEC || w_next == S_WB)
                   ? ALU_OP_RTYPE : ALU_OP_ADD;
      reg_write <= (w_next == S_WB);
      busy      <= (w_next == S_FETCH || w_next == S_DECODE ||
                    w_next == S_EXEC  || w_next == S_WB);
      done      <= (r_state == S_WB) && (w_next == S_IDLE);
      illegal   <= illegal | (w_next == S_TRAP);

      if (r_state == S_IDLE && w_next == S_FETCH) begin
        zero_seen <= 1'b0;
        r_run_cnt <= '0;
      end else if (r_state == S_WB) begin
        zero_seen <= zero_seen | alu_zero;
        r_run_cnt <= w_run_cnt_inc;
      end

      if (r_state == S_WB && instr_cnt != '1) begin
        instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Bench for rtype_sequencer. Three instances share one clock:
//   A: defaults (unlimited run, 16-bit counter) - sequencing, run drop,
//      reset mid-instruction, trap
//   B: MAX_INSTR=6 - six-instruction program that stops by itself
//   C: COUNT_W=2   - counter saturation and zero_seen stickiness
// Every WB pulse on A and B is matched against an expected snapshot queue.

module tb_rtype_sequencer;

  logic clk;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic        rst_a, run_a, az_a;
  logic [5:0]  funct_a;
  logic        pc_a, ir_a, rw_a, busy_a, done_a, ill_a, zs_a;
  logic [1:0]  op_a;
  logic [2:0]  st_a;
  logic [15:0] cnt_a;

  rtype_sequencer #(.COUNT_W(16), .MAX_INSTR(0)) u_a (
    .CLK(clk), .RESET(rst_a), .run(run_a), .funct(funct_a), .alu_zero(az_a),
    .pc_write(pc_a), .ir_write(ir_a), .alu_op(op_a), .reg_write(rw_a),
    .state(st_a), .busy(busy_a), .done(done_a), .illegal(ill_a),
    .zero_seen(zs_a), .instr_cnt(cnt_a)
  );

  // ---------------- DUT B ----------------
  logic        rst_b, run_b, az_b;
  logic [5:0]  funct_b;
  logic        pc_b, ir_b, rw_b, busy_b, done_b, ill_b, zs_b;
  logic [1:0]  op_b;
  logic [2:0]  st_b;
  logic [15:0] cnt_b;

  rtype_sequencer #(.COUNT_W(16), .MAX_INSTR(6)) u_b (
    .CLK(clk), .RESET(rst_b), .run(run_b), .funct(funct_b), .alu_zero(az_b),
    .pc_write(pc_b), .ir_write(ir_b), .alu_op(op_b), .reg_write(rw_b),
    .state(st_b), .busy(busy_b), .done(done_b), .illegal(ill_b),
    .zero_seen(zs_b), .instr_cnt(cnt_b)
  );

  // ---------------- DUT C ----------------
  logic        rst_c, run_c, az_c;
  logic [5:0]  funct_c;
  logic        pc_c, ir_c, rw_c, busy_c, done_c, ill_c, zs_c;
  logic [1:0]  op_c;
  logic [2:0]  st_c;
  logic [1:0]  cnt_c;

  rtype_sequencer #(.COUNT_W(2), .MAX_INSTR(0)) u_c (
    .CLK(clk), .RESET(rst_c), .run(run_c), .funct(funct_c), .alu_zero(az_c),
    .pc_write(pc_c), .ir_write(ir_c), .alu_op(op_c), .reg_write(rw_c),
    .state(st_c), .busy(busy_c), .done(done_c), .illegal(ill_c),
    .zero_seen(zs_c), .instr_cnt(cnt_c)
  );

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;
  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  int rw_b_n;
  int last_rw_b;

  function automatic logic [23:0] snap(input logic [2:0] s, input logic [1:0] op,
                                       input logic pc, input logic ir, input logic bz,
                                       input logic [15:0] c);
    return {s, op, pc, ir, bz, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor A: every reg_write pulse must match the next expected WB snapshot.
  initial begin
    forever begin
      @(negedge clk);
      if (rw_a === 1'b1) begin
        if (exp_a.size() == 0) begin
          check("a_unexpected_reg_write", 32'(rw_a), 32'd0);
        end else begin
          check("a_wb_snapshot", 32'(snap(st_a, op_a, pc_a, ir_a, busy_a, cnt_a)),
                32'(exp_a.pop_front()));
        end
      end
    end
  end

  // Monitor B: WB snapshots plus the 4-cycle spacing between pulses.
  initial begin
    rw_b_n    = 0;
    last_rw_b = 0;
    forever begin
      @(negedge clk);
      if (rw_b === 1'b1) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_reg_write", 32'(rw_b), 32'd0);
        end else begin
          check("b_wb_snapshot", 32'(snap(st_b, op_b, pc_b, ir_b, busy_b, cnt_b)),
                32'(exp_b.pop_front()));
        end
        if (rw_b_n > 0) check("b_rw_gap", 32'(cyc - last_rw_b), 32'd4);
        last_rw_b = cyc;
        rw_b_n++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] prog [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    prog[0] = 6'd32; prog[1] = 6'd36; prog[2] = 6'd37;
    prog[3] = 6'd34; prog[4] = 6'd42; prog[5] = 6'd39;

    rst_a = 1'b1; run_a = 1'b0; funct_a = 6'd32; az_a = 1'b0;
    rst_b = 1'b1; run_b = 1'b0; funct_b = 6'd32; az_b = 1'b0;
    rst_c = 1'b1; run_c = 1'b0; funct_c = 6'd34; az_c = 1'b0;
    ticks(2);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset state
    check("a_rst_state", 32'(st_a), 32'd0);
    check("a_rst_strobes", 32'({pc_a, ir_a, op_a, rw_a, busy_a, done_a, ill_a, zs_a}), 32'd0);
    check("a_rst_cnt", 32'(cnt_a), 32'd0);

    // Basic sequencing, first reg_write in the 4th cycle after run rises
    exp_a.push_back(snap(3'd4, 2'b10, 1'b0, 1'b0, 1'b1, 16'd0));
    run_a = 1'b1;
    tick();
    check("a_fetch_state", 32'(st_a), 32'd1);
    check("a_fetch_strobes", 32'({pc_a, ir_a, rw_a, op_a, busy_a}), 32'b11_0_00_1);
    tick();
    check("a_decode_state", 32'(st_a), 32'd2);
    check("a_decode_strobes", 32'({pc_a, ir_a, rw_a, op_a}), 32'b0_0_0_10);
    tick();
    check("a_exec_state", 32'(st_a), 32'd3);
    tick();
    check("a_wb_state", 32'(st_a), 32'd4);
    exp_a.push_back(snap(3'd4, 2'b10, 1'b0, 1'b0, 1'b1, 16'd1));
    tick();
    check("a_refetch_state", 32'(st_a), 32'd1);
    check("a_cnt_after_wb1", 32'(cnt_a), 32'd1);

    // run dropped during EXEC: instruction completes, then IDLE with done
    tick();
    tick();
    run_a = 1'b0;
    tick();
    check("a_wb2_state", 32'(st_a), 32'd4);
    tick();
    check("a_stop_state", 32'(st_a), 32'd0);
    check("a_done_pulse", 32'(done_a), 32'd1);
    check("a_cnt_after_wb2", 32'(cnt_a), 32'd2);
    check("a_busy_idle", 32'(busy_a), 32'd0);
    tick();
    check("a_done_cleared", 32'(done_a), 32'd0);
    check("a_idle_hold", 32'(st_a), 32'd0);

    // RESET during EXEC: no write, counter cleared, no done
    run_a = 1'b1;
    ticks(3);
    check("a_exec_before_rst", 32'(st_a), 32'd3);
    rst_a = 1'b1;
    tick();
    check("a_midrst_state", 32'(st_a), 32'd0);
    check("a_midrst_rw", 32'(rw_a), 32'd0);
    check("a_midrst_cnt", 32'(cnt_a), 32'd0);
    check("a_midrst_done", 32'(done_a), 32'd0);
    rst_a = 1'b0; run_a = 1'b0;
    tick();
    check("a_midrst_done_after", 32'(done_a), 32'd0);

    // Illegal funct traps; run is ignored; only RESET leaves TRAP
    run_a = 1'b1; funct_a = 6'h3F;
    ticks(2);
    tick();
    check("a_trap_state", 32'(st_a), 32'd5);
    check("a_trap_illegal", 32'(ill_a), 32'd1);
    check("a_trap_strobes", 32'({pc_a, ir_a, op_a, rw_a, busy_a}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      run_a = i[0];
      tick();
      check("a_trap_hold", 32'({st_a, ill_a}), 32'({3'd5, 1'b1}));
    end
    rst_a = 1'b1;
    tick();
    check("a_trap_rst_state", 32'(st_a), 32'd0);
    check("a_trap_rst_illegal", 32'(ill_a), 32'd0);
    rst_a = 1'b0; run_a = 1'b0;

    // Six-instruction program with MAX_INSTR=6
    run_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      funct_b = prog[i];
      exp_b.push_back(snap(3'd4, 2'b10, 1'b0, 1'b0, 1'b1, 16'(i)));
      ticks(4);
    end
    tick();
    run_b = 1'b0;
    check("b_stop_state", 32'(st_b), 32'd0);
    check("b_done_pulse", 32'(done_b), 32'd1);
    check("b_cnt", 32'(cnt_b), 32'd6);
    tick();
    check("b_done_once", 32'(done_b), 32'd0);
    check("b_idle_hold", 32'(st_b), 32'd0);
    check("b_rw_count", 32'(rw_b_n), 32'd6);

    // 2-bit counter saturation and zero_seen
    run_c = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      ticks(3);
      az_c = (k == 3);
      if (k == 5) run_c = 1'b0;
      tick();
      az_c = 1'b0;
      check("c_cnt", 32'(cnt_c), (k < 3) ? 32'(k) : 32'd3);
      check("c_zero_seen", 32'(zs_c), (k >= 3) ? 32'd1 : 32'd0);
      check("c_state_after_wb", 32'(st_c), (k < 5) ? 32'd1 : 32'd0);
    end
    check("c_done", 32'(done_c), 32'd1);
    run_c = 1'b1;
    tick();
    check("c_refetch_state", 32'(st_c), 32'd1);
    check("c_zero_cleared", 32'(zs_c), 32'd0);
    run_c = 1'b0;

    tick();
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
